gray_rgb_frame_ctrl: RTL and testbench

Frame-level sequencer for the grayscale-to-RGB output stage of the Sobel pipeline. On start, it walks the grayscale frame buffer in raster order and issues BRAM reads. It generates the valid strobe into the grayscale-to-RGB converter, aligned to BRAM read latency, and writes the converter's RGB result into the RGB output buffer with a matching write address. It tracks in-flight pixels, pulses frame completion after the last write, and flags protocol errors.

---
 rtl/gray_rgb_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_gray_rgb_frame_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_rgb_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gray_rgb_frame_ctrl
// Purpose  : Frame sequencer for the grayscale-to-RGB output stage. It walks
//            the grayscale buffer in raster order and aligns the converter
//            valid strobe to the BRAM read latency. It also writes converter
//            results to the RGB buffer, counts in-flight pixels and reports
//            frame completion and protocol errors.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            start_i, pause_i         - frame start (IDLE only), issue stall
//            gray_en_o, gray_addr_o   - grayscale BRAM read port
//            conv_valid_o             - converter input strobe
//            conv_done_i, conv_*_i    - converter result handshake and data
//            wr_en_o, wr_addr_o,
//            wr_data_o                - RGB buffer write port, {r,g,b}
//            busy_o, frame_done_o,
//            err_o                    - status (err_o is sticky)
// Revision : 1.0 - initial release
// ============================================================================
module gray_rgb_frame_ctrl #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              pause_i,
    output logic              gray_en_o,
    output logic [ADDR_W-1:0] gray_addr_o,
    output logic              conv_valid_o,
    input  logic              conv_done_i,
    input  logic [7:0]        conv_r_i,
    input  logic [7:0]        conv_g_i,
    input  logic [7:0]        conv_b_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [23:0]       wr_data_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              err_o
);

    localparam int                c_NPIX  = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(c_NPIX - 1);
    localparam int                c_OUT_W = $clog2(RD_LAT + 3) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_rd_cnt;
    logic [ADDR_W-1:0]  r_wr_cnt;
    logic [RD_LAT-1:0]  r_vdly;
    logic [c_OUT_W-1:0] r_outstanding;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [23:0]        r_wr_data;
    logic               r_busy;
    logic               r_frame_done;
    logic               r_err;

    logic               w_issue;
    logic [c_OUT_W-1:0] w_pending;
    logic               w_accept;

    // Issue is decided in the same cycle as pause_i so a pause stalls the
    // very next address without a cycle of skid.
    assign w_issue = (r_state == S_RUN) && !pause_i;

    // The outstanding counter releases a pixel when its write retires, one
    // cycle after the converter answered. Subtracting the write in flight
    // gives the number of pixels still waiting for an answer, which is what
    // decides whether a conv_done_i is legitimate.
    assign w_pending = r_outstanding - {{(c_OUT_W-1){1'b0}}, r_wr_en};
    assign w_accept  = conv_done_i && (w_pending != '0);

    // Valid strobe delay line, RD_LAT stages deep.
    generate
        if (RD_LAT == 1) begin : g_vdly_single
            always_ff @(posedge clk) begin
                if (rst) r_vdly <= '0;
                else     r_vdly <= w_issue;
            end
        end else begin : g_vdly_multi
            always_ff @(posedge clk) begin
                if (rst) r_vdly <= '0;
                else     r_vdly <= {r_vdly[RD_LAT-2:0], w_issue};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rd_cnt      <= '0;
            r_wr_cnt      <= '0;
            r_outstanding <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            // Write stage
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= r_wr_cnt;
                r_wr_data <= {conv_r_i, conv_g_i, conv_b_i};
                r_wr_cnt  <= r_wr_cnt + ADDR_W'(1);
            end
            if (conv_done_i && !w_accept) begin
                r_err <= 1'b1;
            end

            r_outstanding <= r_outstanding
                             + {{(c_OUT_W-1){1'b0}}, w_issue}
                             - {{(c_OUT_W-1){1'b0}}, r_wr_en};

            // Frame sequencing
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state  <= S_RUN;
                        r_rd_cnt <= '0;
                        r_wr_cnt <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
                        if (r_rd_cnt == c_LAST) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_state      <= S_DONE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_frame_done <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gray_en_o    = w_issue;
    assign gray_addr_o  = r_rd_cnt;
    assign conv_valid_o = r_vdly[RD_LAT-1];
    assign wr_en_o      = r_wr_en;
    assign wr_addr_o    = r_wr_addr;
    assign wr_data_o    = r_wr_data;
    assign busy_o       = r_busy;
    assign frame_done_o = r_frame_done;
    assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gray_rgb_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_rgb_frame_ctrl
// Purpose  : Self-checking bench for gray_rgb_frame_ctrl. Two instances
//            (RD_LAT=1 and RD_LAT=3, 4x2 frame) share stimulus; each has
//            its own BRAM and converter model. Expected per-cycle outputs
//            come from a frame-level timing model computed from the pause
//            pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_rgb_frame_ctrl;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int AW  = 19;
    localparam int N   = W * H;
    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0, start3 = 1'b0, pause = 1'b0, inj = 1'b0;

    always #5 clk = ~clk;

    // Instance signals: suffix 1 -> RD_LAT=1, suffix 3 -> RD_LAT=3
    logic          en1, cv1, we1, bz1, fd1, er1, cdone1, cd1;
    logic [AW-1:0] ga1, wa1;
    logic [23:0]   wd1;
    logic [7:0]    d1, cg1;

    logic          en3, cv3, we3, bz3, fd3, er3, cdone3, cd3;
    logic [AW-1:0] ga3, wa3;
    logic [23:0]   wd3;
    logic [7:0]    d3 [3];
    logic [7:0]    cg3;

    function automatic logic [7:0] gval(input int a);
        return 8'((a * 16 + 1) & 255);
    endfunction

    // BRAM models: data for the address of cycle t is presented at t+RD_LAT.
    // Converter models: one-cycle latency, gray replicated on r/g/b.
    always @(posedge clk) begin
        d1     <= gval(int'(ga1));
        cdone1 <= rst ? 1'b0 : cv1;
        cg1    <= d1;
        d3[0]  <= gval(int'(ga3));
        d3[1]  <= d3[0];
        d3[2]  <= d3[1];
        cdone3 <= rst ? 1'b0 : cv3;
        cg3    <= d3[2];
    end
    assign cd1 = cdone1 | inj;
    assign cd3 = cdone3 | inj;

    gray_rgb_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .pause_i(pause),
        .gray_en_o(en1), .gray_addr_o(ga1), .conv_valid_o(cv1),
        .conv_done_i(cd1), .conv_r_i(cg1), .conv_g_i(cg1), .conv_b_i(cg1),
        .wr_en_o(we1), .wr_addr_o(wa1), .wr_data_o(wd1),
        .busy_o(bz1), .frame_done_o(fd1), .err_o(er1)
    );

    gray_rgb_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .start_i(start3), .pause_i(pause),
        .gray_en_o(en3), .gray_addr_o(ga3), .conv_valid_o(cv3),
        .conv_done_i(cd3), .conv_r_i(cg3), .conv_g_i(cg3), .conv_b_i(cg3),
        .wr_en_o(we3), .wr_addr_o(wa3), .wr_data_o(wd3),
        .busy_o(bz3), .frame_done_o(fd3), .err_o(er3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Pause pattern and expected per-cycle outputs for each instance.
    int p      [MAXC];
    int e_en   [2][MAXC];
    int e_addr [2][MAXC];
    int e_cv   [2][MAXC];
    int e_we   [2][MAXC];
    int e_wa   [2][MAXC];
    int e_bz   [2][MAXC];
    int e_fd   [2][MAXC];
    int wlast  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Frame model: the k-th unpaused cycle from cycle 1 issues pixel k; it is
    // valid at +lat, written at +lat+2. Busy spans cycle 1 up to one cycle
    // after the last write, and frame_done follows the cycle after that.
    task automatic build_exp(input int i, input int lat);
        int k, last;
        for (int c = 0; c < MAXC; c++) begin
            e_en[i][c] = 0; e_addr[i][c] = 0; e_cv[i][c] = 0;
            e_we[i][c] = 0; e_wa[i][c] = 0; e_bz[i][c] = 0; e_fd[i][c] = 0;
        end
        k = 0;
        last = 0;
        for (int c = 1; c < MAXC - 8 && k < N; c++) begin
            if (p[c] == 0) begin
                e_en[i][c]         = 1;
                e_addr[i][c]       = k;
                e_cv[i][c+lat]     = 1;
                e_we[i][c+lat+2]   = 1;
                e_wa[i][c+lat+2]   = k;
                k++;
                last = c;
            end
        end
        wlast[i] = last + lat + 2;
        for (int c = 1; c <= wlast[i] + 1; c++) e_bz[i][c] = 1;
        e_fd[i][wlast[i] + 2] = 1;
    endtask

    task automatic check_cycle(input int i, input int c, input logic exp_err);
        logic ge, cv, we, bz, fd, er;
        logic [AW-1:0] ga, wa;
        logic [23:0] wd, exp_wd;
        string t;
        if (i == 0) begin
            ge = en1; ga = ga1; cv = cv1; we = we1; wa = wa1; wd = wd1; bz = bz1; fd = fd1; er = er1;
        end else begin
            ge = en3; ga = ga3; cv = cv3; we = we3; wa = wa3; wd = wd3; bz = bz3; fd = fd3; er = er3;
        end
        t = $sformatf("lat%0d cyc%0d", (i == 0) ? 1 : 3, c);
        chk({t, " gray_en"}, 32'(ge), 32'(e_en[i][c]));
        if (e_en[i][c] != 0) chk({t, " gray_addr"}, 32'(ga), 32'(e_addr[i][c]));
        chk({t, " conv_valid"}, 32'(cv), 32'(e_cv[i][c]));
        chk({t, " wr_en"}, 32'(we), 32'(e_we[i][c]));
        if (e_we[i][c] != 0) begin
            exp_wd = {3{gval(e_wa[i][c])}};
            chk({t, " wr_addr"}, 32'(wa), 32'(e_wa[i][c]));
            chk({t, " wr_data"}, 32'(wd), 32'(exp_wd));
        end
        chk({t, " busy"}, 32'(bz), 32'(e_bz[i][c]));
        chk({t, " frame_done"}, 32'(fd), 32'(e_fd[i][c]));
        chk({t, " err"}, 32'(er), 32'(exp_err));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " l1 gray_en"},   32'(en1), 32'd0);
        chk({tag, " l1 gray_addr"}, 32'(ga1), 32'd0);
        chk({tag, " l1 conv_valid"},32'(cv1), 32'd0);
        chk({tag, " l1 wr_en"},     32'(we1), 32'd0);
        chk({tag, " l1 wr_addr"},   32'(wa1), 32'd0);
        chk({tag, " l1 wr_data"},   32'(wd1), 32'd0);
        chk({tag, " l1 busy"},      32'(bz1), 32'd0);
        chk({tag, " l1 frame_done"},32'(fd1), 32'd0);
        chk({tag, " l1 err"},       32'(er1), 32'd0);
        chk({tag, " l3 gray_en"},   32'(en3), 32'd0);
        chk({tag, " l3 conv_valid"},32'(cv3), 32'd0);
        chk({tag, " l3 wr_en"},     32'(we3), 32'd0);
        chk({tag, " l3 wr_data"},   32'(wd3), 32'd0);
        chk({tag, " l3 busy"},      32'(bz3), 32'd0);
        chk({tag, " l3 err"},       32'(er3), 32'd0);
    endtask

    // One frame on both instances; inputs change #1 after the edge and
    // outputs are sampled #2 after the edge.
    task automatic run_frame(input int hold);
        int last;
        build_exp(0, 1);
        build_exp(1, 3);
        last = ((wlast[0] > wlast[1]) ? wlast[0] : wlast[1]) + 4;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            start1 = (c == 0) || (hold != 0 && c <= wlast[0] + 2);
            start3 = (c == 0) || (hold != 0 && c <= wlast[1] + 2);
            pause  = p[c][0];
            #1;
            check_cycle(0, c, 1'b0);
            check_cycle(1, c, 1'b0);
        end
        start1 = 1'b0;
        start3 = 1'b0;
        pause  = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #2;
        check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Plain frame, no pause
        for (int c = 0; c < MAXC; c++) p[c] = 0;
        run_frame(0);

        // Pause on issue cycles 3-5, alternating afterwards
        for (int c = 0; c < MAXC; c++) p[c] = (c >= 3 && c <= 5) ? 1 : ((c > 5) ? (c % 2) : 0);
        run_frame(0);

        // Random pause patterns
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < MAXC; c++) p[c] = (c < 150 && $urandom_range(0, 2) == 0) ? 1 : 0;
            run_frame(0);
        end

        // start_i held through the frame: exactly one frame per instance
        for (int c = 0; c < MAXC; c++) p[c] = 0;
        run_frame(1);

        // Reset in cycle 6 of a frame
        @(posedge clk);
        #1 start1 = 1'b1; start3 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1 start1 = 1'b0; start3 = 1'b0;
            if (c == 6) rst = 1'b1;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_zero("midreset");
        run_frame(0);

        // Spurious conv_done_i in IDLE
        @(posedge clk);
        #1 inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        #1;
        chk("spurious l1 err",   32'(er1), 32'd1);
        chk("spurious l1 wr_en", 32'(we1), 32'd0);
        chk("spurious l3 err",   32'(er3), 32'd1);
        chk("spurious l3 wr_en", 32'(we3), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        chk("sticky l1 err", 32'(er1), 32'd1);
        chk("sticky l3 err", 32'(er3), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
